rr_mux16_arbiter: RTL and testbench
===================================

Name: rr_mux16_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 mux bank (a bus built from mux16_1 slices) among 16 requesters.
- Produces a registered one-hot grant and the matching 4-bit select. sel[3:0] maps directly onto {sel3, sel2, sel1, sel0} of every mux16_1 in the bank.
- Enforces a per-grant hold limit so no requester starves the others.
- Sits between the requesting units and the shared read-path mux bank.

Parameters:
- MAX_HOLD, 8: max consecutive cycles one requester keeps the grant while others are waiting. 0 = unlimited. Legal range 0..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  16  request vector; bit i = requester i wants the mux.
- grant  output  16  registered one-hot grant; all zero when idle.
- sel  output  4  registered index of the granted requester; drives the mux bank selects.
- sel_valid  output  1  high while grant is nonzero.
- hold_cnt  output  8  cycles the current grant has been held, saturating.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - grant=0, sel=0, sel_valid=0, hold_cnt=0.
  - Priority pointer ptr=0; state IDLE.
- Arbitration function:
  - Search the candidate vector starting at index ptr, ascending, wrapping 15->0.
  - The first set bit wins. Implement as a rotate-and-priority-encode over 16 bits.
- IDLE:
  - If req!=0 at an edge, next state is GRANT with winner g.
  - On that edge: grant=1<<g, sel=g, sel_valid=1, hold_cnt=1.
  - Latency: req sampled at edge k gives grant visible after edge k.
  - If req==0, remain IDLE.
- GRANT (current owner g), evaluated each edge:
  - Release condition: req[g]==0, OR (MAX_HOLD!=0 AND hold_cnt>=MAX_HOLD AND (req & ~(1<<g))!=0).
  - On release, ptr <= (g+1) mod 16. Arbitrate over req & ~(1<<g) from the new ptr in the same cycle.
  - If a winner w exists: grant moves directly to w on that edge, sel=w, hold_cnt=1. No idle bubble.
  - If no winner: grant=0, sel_valid=0, hold_cnt=0, state IDLE. sel keeps its last value.
  - No release: grant unchanged; hold_cnt increments and saturates at 255.
- Hold limit with no competitor: owner keeps the grant past MAX_HOLD. As soon as another req is sampled high, release happens at that edge.
- ptr updates only on release. A grant from IDLE uses the current ptr.
- Deassertion of req by a non-owner has no effect.
- Simultaneous release by owner g and new requests: the new requests are arbitrated from g+1. The owner's own bit is never re-granted back-to-back while others request.
- Fairness: with MAX_HOLD!=0, a continuously requesting requester is granted within 15 grants.
- Invariants:
  - grant is always one-hot or zero.
  - sel equals the index of the set grant bit whenever sel_valid=1.
  - sel_valid == (grant!=0).
- Reset mid-grant: outputs clear immediately, ptr=0. The first grant after reset deassertion follows the IDLE rules.

Test Plan:
- Reset: hold reset=0 with req=16'hFFFF -> grant=0, sel=0, sel_valid=0, hold_cnt=0 at all times.
- Single requester: req=16'h0020 for 4 edges, then 0 -> grant=16'h0020, sel=5, sel_valid=1 after the first edge; hold_cnt 1..4; grant=0 and sel_valid=0 one edge after req drops; sel stays 5.
- Full load, MAX_HOLD=8, req=16'hFFFF constant -> owners rotate 0,1,...,15,0; each holds exactly 8 cycles; no cycle with grant=0.
- Wrap-around: owner 13 releases (ptr becomes 14) with req bits 2 and 15 set -> grant=16'h8000 next; after it releases, grant=16'h0004.
- Hold saturation, MAX_HOLD=8: req[3] alone for 20 cycles -> grant stays 16'h0008, hold_cnt=20. Then assert req[9] -> grant=16'h0200, sel=9 at the next edge.
- Async reset mid-grant: owner 7, pull reset low between edges -> outputs zero before the next edge. Release reset with req=16'h0081 -> first grant=16'h0001 (ptr=0).

Source files
------------

// File: rtl/rr_mux16_arbiter_if.sv
// rtl/rr_mux16_arbiter_if.sv - request/grant bundle between requesters and the mux-bank arbiter
interface rr_mux16_arbiter_if;
   logic [15:0] req;
   logic [15:0] grant;
   logic [3:0]  sel;
   logic        sel_valid;
   logic [7:0]  hold_cnt;

   modport master (
      output req,
      input  grant,
      input  sel,
      input  sel_valid,
      input  hold_cnt
   );

   modport slave (
      input  req,
      output grant,
      output sel,
      output sel_valid,
      output hold_cnt
   );
endinterface

// File: rtl/rr_mux16_arbiter.sv
// rtl/rr_mux16_arbiter.sv - round-robin owner of a 16:1 mux bank with a per-grant hold limit
module rr_mux16_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                clk,
   input  logic                reset,
   rr_mux16_arbiter_if.slave   arb
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
   localparam bit         LIMIT_ON = (MAX_HOLD != 0);

   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [15:0] grant_q, grant_d;
   logic [3:0]  sel_q, sel_d;
   logic [7:0]  hold_q, hold_d;

   logic [15:0] others;
   logic        release_now;
   logic [4:0]  pick;
   logic [3:0]  next_ptr;

   // Returns {found, index}: first set bit of cand searching upward from start, wrapping 15->0.
   function automatic logic [4:0] rr_pick(input logic [15:0] cand, input logic [3:0] start);
      logic [15:0] rot;
      logic [4:0]  res;
      rot = 16'({cand, cand} >> start);
      res = 5'd0;
      for (int i = 15; i >= 0; i--) begin
         if (rot[i]) begin
            res = {1'b1, start + 4'(i)};
         end
      end
      return res;
   endfunction

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      sel_d       = sel_q;
      hold_d      = hold_q;
      others      = arb.req & ~grant_q;
      release_now = 1'b0;
      next_ptr    = sel_q + 4'd1;
      pick        = 5'd0;

      unique case (state_q)
         ST_IDLE: begin
            pick = rr_pick(arb.req, ptr_q);
            if (pick[4]) begin
               state_d = ST_GRANT;
               grant_d = 16'd1 << pick[3:0];
               sel_d   = pick[3:0];
               hold_d  = 8'd1;
            end
         end
         ST_GRANT: begin
            release_now = !arb.req[sel_q] ||
                          (LIMIT_ON && (hold_q >= HOLD_LIM) && (others != 16'd0));
            if (release_now) begin
               // Owner's bit is excluded so it cannot win back-to-back against others.
               ptr_d = next_ptr;
               pick  = rr_pick(others, next_ptr);
               if (pick[4]) begin
                  grant_d = 16'd1 << pick[3:0];
                  sel_d   = pick[3:0];
                  hold_d  = 8'd1;
               end else begin
                  state_d = ST_IDLE;
                  grant_d = 16'd0;
                  hold_d  = 8'd0;
               end
            end else if (hold_q != 8'hFF) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 16'd0;
            hold_d  = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= 4'd0;
         grant_q <= 16'd0;
         sel_q   <= 4'd0;
         hold_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         hold_q  <= hold_d;
      end
   end

   assign arb.grant     = grant_q;
   assign arb.sel       = sel_q;
   assign arb.sel_valid = (grant_q != 16'd0);
   assign arb.hold_cnt  = hold_q;

endmodule

// File: tb/tb_rr_mux16_arbiter.sv
// tb/tb_rr_mux16_arbiter.sv - directed vectors with queued expectations checked by a monitor
module tb_rr_mux16_arbiter;

   typedef struct {
      logic [15:0] g;
      logic [3:0]  s;
      logic        v;
      logic [7:0]  h;
      string       tag;
   } exp_t;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;
   exp_t exp_q[$];

   rr_mux16_arbiter_if arb_if ();

   rr_mux16_arbiter #(.MAX_HOLD(8)) dut (
      .clk   (clk),
      .reset (reset),
      .arb   (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, want);
   endtask

   task automatic step(input logic rst_v, input logic [15:0] r, input logic [15:0] eg,
                       input logic [3:0] es, input logic ev, input logic [7:0] eh, input string tag);
      exp_t e;
      @(negedge clk);
      reset = rst_v;
      arb_if.req = r;
      e.g = eg; e.s = es; e.v = ev; e.h = eh; e.tag = tag;
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({e.tag, ".grant"},     32'(arb_if.grant),     32'(e.g));
         chk({e.tag, ".sel"},       32'(arb_if.sel),       32'(e.s));
         chk({e.tag, ".sel_valid"}, 32'(arb_if.sel_valid), 32'(e.v));
         chk({e.tag, ".hold_cnt"},  32'(arb_if.hold_cnt),  32'(e.h));
      end
   end

   initial begin
      n_chk = 0;
      n_pass = 0;
      reset = 1'b0;
      arb_if.req = 16'h0000;

      repeat (3) step(1'b0, 16'hFFFF, 16'h0000, 4'd0, 1'b0, 8'd0, "reset_hold");
      repeat (2) step(1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 8'd0, "idle");

      for (int i = 1; i <= 4; i++)
         step(1'b1, 16'h0020, 16'h0020, 4'd5, 1'b1, 8'(i), "single");
      repeat (2) step(1'b1, 16'h0000, 16'h0000, 4'd5, 1'b0, 8'd0, "single_drop");

      // ptr=6: requester 13 wins, then wraps through 15 to 2
      step(1'b1, 16'h2000, 16'h2000, 4'd13, 1'b1, 8'd1, "wrap_own13");
      step(1'b1, 16'h8004, 16'h8000, 4'd15, 1'b1, 8'd1, "wrap_to15");
      step(1'b1, 16'h0004, 16'h0004, 4'd2,  1'b1, 8'd1, "wrap_to2");
      step(1'b1, 16'h0000, 16'h0000, 4'd2,  1'b0, 8'd0, "wrap_idle");

      // ptr=3: lone requester keeps the grant past the limit
      for (int i = 1; i <= 20; i++)
         step(1'b1, 16'h0008, 16'h0008, 4'd3, 1'b1, 8'(i), "sat_hold");
      step(1'b1, 16'h0208, 16'h0200, 4'd9, 1'b1, 8'd1, "sat_preempt");
      step(1'b1, 16'h0200, 16'h0200, 4'd9, 1'b1, 8'd2, "nonowner_drop");
      for (int i = 3; i <= 8; i++)
         step(1'b1, 16'h0208, 16'h0200, 4'd9, 1'b1, 8'(i), "limit_hold");
      step(1'b1, 16'h0208, 16'h0008, 4'd3, 1'b1, 8'd1, "limit_release");
      step(1'b1, 16'h0000, 16'h0000, 4'd3, 1'b0, 8'd0, "limit_idle");

      // ptr=4: full load rotates every 8 cycles without a gap
      for (int c = 0; c < 136; c++)
         step(1'b1, 16'hFFFF, 16'd1 << ((4 + c / 8) % 16), 4'((4 + c / 8) % 16),
              1'b1, 8'(c % 8 + 1), "full_load");
      step(1'b1, 16'h0000, 16'h0000, 4'd4, 1'b0, 8'd0, "full_idle");

      // ptr=5: owner 7, then reset between edges
      step(1'b1, 16'h0080, 16'h0080, 4'd7, 1'b1, 8'd1, "pre_rst");
      step(1'b1, 16'h0080, 16'h0080, 4'd7, 1'b1, 8'd2, "pre_rst");
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("async_rst.grant",     32'(arb_if.grant),     32'h0);
      chk("async_rst.sel",       32'(arb_if.sel),       32'h0);
      chk("async_rst.sel_valid", 32'(arb_if.sel_valid), 32'h0);
      chk("async_rst.hold_cnt",  32'(arb_if.hold_cnt),  32'h0);
      step(1'b0, 16'h0081, 16'h0000, 4'd0, 1'b0, 8'd0, "rst_low");
      step(1'b1, 16'h0081, 16'h0001, 4'd0, 1'b1, 8'd1, "post_rst");
      step(1'b1, 16'h0081, 16'h0001, 4'd0, 1'b1, 8'd2, "post_rst");
      step(1'b1, 16'h0080, 16'h0080, 4'd7, 1'b1, 8'd1, "post_rst_move");
      step(1'b1, 16'h0000, 16'h0000, 4'd7, 1'b0, 8'd0, "post_rst_idle");

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
